// File: rtl/int_to_bf16_conv_pkg.sv
// Shared BF16 definitions: field widths, bias, canonical zero and the
// converter state encoding. Also used by the BF16 adder datapath.
package int_to_bf16_conv_pkg;

  localparam int unsigned BF16_W     = 32'd16;
  localparam int unsigned BF16_EXP_W = 32'd8;
  localparam int unsigned BF16_MAN_W = 32'd7;
  localparam int unsigned BF16_BIAS  = 32'd127;
  localparam logic [15:0] BF16_ZERO  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  // Assemble a BF16 word from its three fields.
  function automatic logic [15:0] bf16_word(
    input logic                  sign,
    input logic [BF16_EXP_W-1:0] exp,
    input logic [BF16_MAN_W-1:0] man
  );
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/int_to_bf16_conv_if.sv
// Ready/valid bundle between an integer producer, the converter and the
// BF16 consumer. The master drives the request and accepts the result.
interface int_to_bf16_conv_if #(
  parameter int IN_W = 16
);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );

endinterface

// File: rtl/int_to_bf16_conv_pack.sv
// Combinational packer: turns a normalised magnitude (leading one already
// at the top, so only the bits below it are passed in) plus sign and
// exponent into a truncated BF16 word and a flag for discarded bits.
module int_to_bf16_conv_pack
  import int_to_bf16_conv_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                  sign,
  input  logic [BF16_EXP_W-1:0] exp,
  input  logic [IN_W-2:0]       frac,
  output logic [15:0]           data,
  output logic                  inexact
);

  logic [BF16_MAN_W-1:0] man_s;
  logic                  lost_s;

  // Top fraction bits become the mantissa; anything below is truncated.
  always_comb begin
    man_s   = frac[IN_W-2 -: BF16_MAN_W];
    lost_s  = |frac[IN_W-2-BF16_MAN_W:0];
    data    = bf16_word(sign, exp, man_s);
    inexact = lost_s;
  end

endmodule

// File: rtl/int_to_bf16_conv.sv
// Signed integer to BF16 converter. Accepts one integer, finds its leading
// one by shifting one position per cycle while counting the exponent down,
// then packs a round-toward-zero BF16 result and holds it until taken.
module int_to_bf16_conv
  import int_to_bf16_conv_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  int_to_bf16_conv_if.slave   bus
);

  // Exponent of the MSB position of an IN_W-bit magnitude.
  localparam logic [BF16_EXP_W-1:0] EXP_INIT = BF16_EXP_W'(BF16_BIAS + IN_W - 1);
  localparam logic [IN_W-1:0]       ONE_W    = {{(IN_W-1){1'b0}}, 1'b1};

  state_e                state_r, state_nxt_s;
  logic                  sign_r, sign_nxt_s;
  logic [IN_W-1:0]       mag_r, mag_nxt_s;
  logic [BF16_EXP_W-1:0] exp_r, exp_nxt_s;
  logic [15:0]           out_data_r, out_data_nxt_s;
  logic                  out_inexact_r, out_inexact_nxt_s;
  logic                  out_valid_r, out_valid_nxt_s;
  logic                  in_ready_r, in_ready_nxt_s;

  logic [IN_W-1:0]       abs_s;
  logic [15:0]           pack_data_s;
  logic                  pack_inexact_s;

  int_to_bf16_conv_pack #(.IN_W(IN_W)) u_pack (
    .sign    (sign_r),
    .exp     (exp_r),
    .frac    (mag_r[IN_W-2:0]),
    .data    (pack_data_s),
    .inexact (pack_inexact_s)
  );

  // Magnitude of the incoming value; the most negative input maps to 2^(IN_W-1).
  always_comb begin
    if (bus.in_data[IN_W-1]) begin
      abs_s = ~bus.in_data + ONE_W;
    end else begin
      abs_s = bus.in_data;
    end
  end

  // Next-state and datapath update for the IDLE/NORM/DONE sequence.
  always_comb begin
    state_nxt_s       = state_r;
    sign_nxt_s        = sign_r;
    mag_nxt_s         = mag_r;
    exp_nxt_s         = exp_r;
    out_data_nxt_s    = out_data_r;
    out_inexact_nxt_s = out_inexact_r;

    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          sign_nxt_s = bus.in_data[IN_W-1];
          mag_nxt_s  = abs_s;
          exp_nxt_s  = EXP_INIT;
          if (abs_s == '0) begin
            // Zero is emitted directly and always as positive zero.
            out_data_nxt_s    = BF16_ZERO;
            out_inexact_nxt_s = 1'b0;
            state_nxt_s       = DONE;
          end else begin
            state_nxt_s = NORM;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      NORM: begin
        if (!mag_r[IN_W-1]) begin
          mag_nxt_s = {mag_r[IN_W-2:0], 1'b0};
          exp_nxt_s = exp_r - 8'd1;
        end else begin
          out_data_nxt_s    = pack_data_s;
          out_inexact_nxt_s = pack_inexact_s;
          state_nxt_s       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Handshake flags are registered from the state being entered.
    out_valid_nxt_s = (state_nxt_s == DONE);
    in_ready_nxt_s  = (state_nxt_s == IDLE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      sign_r        <= 1'b0;
      mag_r         <= '0;
      exp_r         <= '0;
      out_data_r    <= BF16_ZERO;
      out_inexact_r <= 1'b0;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      sign_r        <= sign_nxt_s;
      mag_r         <= mag_nxt_s;
      exp_r         <= exp_nxt_s;
      out_data_r    <= out_data_nxt_s;
      out_inexact_r <= out_inexact_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      in_ready_r    <= in_ready_nxt_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_inexact = out_inexact_r;

endmodule

// File: tb/tb_int_to_bf16_conv.sv
// Directed bench for the integer to BF16 converter with IN_W=16.
module tb_int_to_bf16_conv;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   lat;

  int_to_bf16_conv_if #(.IN_W(16)) bus ();

  int_to_bf16_conv #(.IN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Present a value at a negedge and let the next posedge accept it.
  task automatic accept(input logic [15:0] val, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic take_output;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic convert(input logic [15:0] val, input logic [15:0] exp_data,
                         input logic exp_inx, input int exp_lat, input string tag);
    int n;
    accept(val, tag);
    wait_valid(n);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, exp_data});
    check({tag, "_inexact"}, {31'd0, bus.out_inexact}, {31'd0, exp_inx});
    take_output();
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
    check("rst_out_data",  {16'd0, bus.out_data},    32'd0);
    check("rst_inexact",   {31'd0, bus.out_inexact}, 32'd0);

    // Latency is lz+1 edges after accept for nonzero, 0 for zero.
    convert(16'sd1,      16'h3F80, 1'b0, 16, "one");
    convert(16'sd100,    16'h42C8, 1'b0, 10, "hundred");
    convert(-16'sd3,     16'hC040, 1'b0, 15, "minus3");
    convert(16'sd32767,  16'h46FF, 1'b1, 2,  "max_pos");
    convert(-16'sd32768, 16'hC700, 1'b0, 1,  "min_neg");
    convert(16'h0000,    16'h0000, 1'b0, 0,  "zero_after_neg");
    convert(16'sd255,    16'h437F, 1'b0, 9,  "x255");
    convert(16'sd257,    16'h4380, 1'b1, 8,  "x257");
    convert(-16'sd3,     16'hC040, 1'b0, 15, "minus3_again");
    convert(16'h0000,    16'h0000, 1'b0, 0,  "zero_again");

    // Backpressure: result must hold and new requests must be ignored.
    accept(16'sd100, "bp");
    wait_valid(lat);
    check("bp_latency", lat, 32'd10);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_data",  {16'd0, bus.out_data},  32'h42C8);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", lat, 32'd14);
    check("bp_next_data", {16'd0, bus.out_data}, 32'h40E0);
    take_output();

    // Reset in the middle of normalisation discards the conversion.
    accept(16'sd1, "rst_mid");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_out_data", {16'd0, bus.out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_in_ready",  {31'd0, bus.in_ready},  32'd1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    check("rst_mid_no_stale", lat, 32'd0);
    convert(16'sd2, 16'h4000, 1'b0, 15, "two_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
